// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if -- bundle carrying the pattern-select input and the
// registered video timing/pixel outputs of vga_pattern_gen.
//   mode        : pattern select, driven by the consumer (slave)
//   hsync/vsync : sync pulses at the generator's SYNC_POL level
//   de          : display enable, high in the active region
//   x / y       : pixel coordinates, 0 outside the active region
//   rgb         : RGB222 {R1,R0,G1,G0,B1,B0}
//   frame_start : one-clock pulse aligned with pixel (0,0)
interface vga_pattern_gen_if #(
  parameter int COORD_W = 10
) ();
  logic [1:0]         mode;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [5:0]         rgb;
  logic               frame_start;

  modport master (input mode, output hsync, vsync, de, x, y, rgb, frame_start);
  modport slave  (output mode, input hsync, vsync, de, x, y, rgb, frame_start);
endinterface

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen -- VGA timing generator with four built-in test patterns.
// Ports:
//   clk   : pixel clock (single domain)
//   rst_n : asynchronous active-low reset
//   vid   : vga_pattern_gen_if.master (mode in; hsync, vsync, de, x, y,
//           rgb, frame_start out, all registered in one stage)
// Patterns: 0 colour bars, 1 checkerboard, 2 gradient, 3 border.
// Optional feature: define VGA_SCROLL_EN to add an 8-bit frame counter that
// scrolls the checkerboard and gradient left by one pixel per frame.
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int COORD_W  = 10
) (
  input  logic clk,
  input  logic rst_n,
  vga_pattern_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic SP = (SYNC_POL != 0);

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_ACTIVE - 1);
  localparam logic [COORD_W-1:0] HS_BEG   = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_BEG   = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [COORD_W-1:0] BAR_LAST = COORD_W'(H_ACTIVE / 8 - 1);

  // Counters and pattern state
  logic               r_run;      // low for the first edge after reset
  logic [COORD_W-1:0] r_h_cnt;
  logic [COORD_W-1:0] r_v_cnt;
  logic [COORD_W-1:0] r_bar_cnt;  // position inside the current colour bar
  logic [2:0]         r_bar_idx;
  logic [1:0]         r_mode;

  // Registered outputs
  logic               r_hsync;
  logic               r_vsync;
  logic               r_de;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [5:0]         r_rgb;
  logic               r_fs;

  logic               w_org;
  logic [1:0]         w_mode;
  logic               w_de;
  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic [COORD_W-1:0] w_px;
  logic [5:0]         w_rgb;
  logic [5:0]         w_bar_rgb;
  logic               w_unused;

  assign w_org = (r_h_cnt == '0) && (r_v_cnt == '0);
  // The frame origin pixel is rendered in the same cycle the mode is
  // latched, so it must already see the incoming mode.
  assign w_mode = w_org ? vid.mode : r_mode;

`ifdef VGA_SCROLL_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_frame_cnt <= '0;
    else if (r_run && r_h_cnt == H_LAST && r_v_cnt == V_LAST)
      r_frame_cnt <= r_frame_cnt + 8'd1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run     <= 1'b0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
      r_mode    <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_org) r_mode <= vid.mode;
      if (r_run) begin
        if (r_h_cnt == H_LAST) begin
          r_h_cnt   <= '0;
          r_bar_cnt <= '0;
          r_bar_idx <= '0;
          r_v_cnt   <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
          r_h_cnt <= r_h_cnt + 1'b1;
          if (r_h_cnt < H_ACT) begin
            // The last bar never wraps, so it absorbs the width remainder.
            if (r_bar_cnt == BAR_LAST && r_bar_idx != 3'd7) begin
              r_bar_cnt <= '0;
              r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
              r_bar_cnt <= r_bar_cnt + 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    case (r_bar_idx)
      3'd0:    w_bar_rgb = 6'b111111;
      3'd1:    w_bar_rgb = 6'b111100;
      3'd2:    w_bar_rgb = 6'b001111;
      3'd3:    w_bar_rgb = 6'b001100;
      3'd4:    w_bar_rgb = 6'b110011;
      3'd5:    w_bar_rgb = 6'b110000;
      3'd6:    w_bar_rgb = 6'b000011;
      default: w_bar_rgb = 6'b000000;
    endcase
  end

  always_comb begin
    w_de = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    w_x  = w_de ? r_h_cnt : '0;
    w_y  = w_de ? r_v_cnt : '0;
    w_px = w_x;
`ifdef VGA_SCROLL_EN
    if (w_mode == 2'd1 || w_mode == 2'd2)
      w_px = w_x + COORD_W'(r_frame_cnt);
`endif
    case (w_mode)
      2'd0:    w_rgb = w_bar_rgb;
      2'd1:    w_rgb = (w_px[5] ^ w_y[5]) ? 6'b111111 : 6'b000000;
      2'd2:    w_rgb = {w_px[7:6], w_y[7:6], w_px[8:7]};
      default: w_rgb = (w_x == '0 || w_x == X_LAST || w_y == '0 || w_y == Y_LAST)
                       ? 6'b111111 : 6'b000000;
    endcase
    if (!w_de) w_rgb = '0;
  end

  assign w_unused = ^w_px;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync <= ~SP;
      r_vsync <= ~SP;
      r_de    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_rgb   <= '0;
      r_fs    <= 1'b0;
    end else if (r_run) begin
      r_hsync <= (r_h_cnt >= HS_BEG && r_h_cnt <= HS_LAST) ? SP : ~SP;
      r_vsync <= (r_v_cnt >= VS_BEG && r_v_cnt <= VS_LAST) ? SP : ~SP;
      r_de    <= w_de;
      r_x     <= w_x;
      r_y     <= w_y;
      r_rgb   <= w_rgb;
      r_fs    <= w_org;
    end
  end

  assign vid.hsync       = r_hsync;
  assign vid.vsync       = r_vsync;
  assign vid.de          = r_de;
  assign vid.x           = r_x;
  assign vid.y           = r_y;
  assign vid.rgb         = r_rgb;
  assign vid.frame_start = r_fs;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen -- randomized self-checking bench for vga_pattern_gen
// using a reduced timing so several whole frames fit in a short run.
// The reference computes every output from the pixel index since reset
// release with plain division/modulo arithmetic.
module tb_vga_pattern_gen;
  localparam int HA = 70, HFP = 4, HS = 8, HBP = 6;
  localparam int VA = 40, VFP = 3, VS = 2, VBP = 5;
  localparam int CW = 10;
  localparam bit SP = 1'b0;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam logic [31:0] RST_VEC = {2'b0, ~SP, ~SP, 28'h0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_pattern_gen_if #(.COORD_W(CW)) vid ();

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(0), .COORD_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vid(vid)
  );

  int n_cmp = 0, n_err = 0;
  int kcyc, fmode, last_fs, de_cnt, vs_cnt, hs_run;
  bit have_fs;
  int bars [8] = '{63, 60, 15, 12, 51, 48, 3, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {2'b0, vid.hsync, vid.vsync, vid.de, vid.frame_start, vid.x, vid.y, vid.rgb};
  endfunction

  // Expected outputs for pixel index p after release, frame pattern fm.
  function automatic logic [31:0] exp_pix(int p, int fm);
    int h, v, fr, x, y, px, rgb, idx;
    bit de, hs, vs, fs;
    h  = p % HT;
    v  = (p / HT) % VT;
    fr = p / FT;
    de = (h < HA) && (v < VA);
    x  = de ? h : 0;
    y  = de ? v : 0;
    hs = (h >= HA + HFP && h < HA + HFP + HS) ? SP : !SP;
    vs = (v >= VA + VFP && v < VA + VFP + VS) ? SP : !SP;
    fs = (h == 0 && v == 0);
    px = x;
`ifdef VGA_SCROLL_EN
    if (fm == 1 || fm == 2) px = (x + fr % 256) % (1 << CW);
`else
    if (fr < 0) px = 0;
`endif
    case (fm)
      0: begin idx = x / (HA / 8); if (idx > 7) idx = 7; rgb = bars[idx]; end
      1: rgb = (((px >> 5) ^ (y >> 5)) & 1) != 0 ? 63 : 0;
      2: rgb = (((px >> 6) & 3) << 4) | (((y >> 6) & 3) << 2) | ((px >> 7) & 3);
      default: rgb = (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) ? 63 : 0;
    endcase
    if (!de) rgb = 0;
    return {2'b0, hs, vs, de, fs, 10'(x), 10'(y), 6'(rgb)};
  endfunction

  task automatic restart_stats();
    kcyc = 0; have_fs = 0; de_cnt = 0; vs_cnt = 0; hs_run = 0; last_fs = 0;
  endtask

  task automatic step();
    int p;
    @(posedge clk);
    @(negedge clk);
    kcyc++;
    if (kcyc == 1) begin
      chk("post_release", obs_vec(), RST_VEC);
      return;
    end
    p = kcyc - 2;
    if (p % FT == 0) fmode = int'(vid.mode);
    chk("pix", obs_vec(), exp_pix(p, fmode));
    if (vid.frame_start) begin
      if (have_fs) begin
        chk("fs_period", 32'(kcyc - last_fs), 32'(FT));
        chk("de_per_frame", 32'(de_cnt), 32'(HA * VA));
        chk("vs_per_frame", 32'(vs_cnt), 32'(VS * HT));
      end else begin
        chk("fs_first", 32'(kcyc), 32'd2);
      end
      have_fs = 1; last_fs = kcyc; de_cnt = 0; vs_cnt = 0;
    end
    if (vid.de) de_cnt++;
    if (vid.vsync == SP) vs_cnt++;
    if (vid.hsync == SP) hs_run++;
    else if (hs_run != 0) begin
      chk("hs_width", 32'(hs_run), 32'(HS));
      hs_run = 0;
    end
  endtask

  initial begin
    int p, r1, r2, rst_at;
    rst_n = 1'b0;
    vid.mode = 2'd0;
    fmode = 0;
    restart_stats();
    repeat (3) begin
      @(negedge clk);
      chk("rst_val", obs_vec(), RST_VEC);
    end
    rst_n = 1'b1;
    r1 = 0; r2 = 0;
    // Eight frames; per frame a random mid-frame mode glitch, then the
    // mode for the next frame, both of which must only act at frame start.
    while (kcyc < 8 * FT + 2) begin
      step();
      p = kcyc - 2;
      if (p >= 0) begin
        if (p % FT == 0) begin
          r1 = $urandom_range(200, FT / 2);
          r2 = $urandom_range(FT / 2 + 1, FT - 200);
        end
        if (p % FT == r1) vid.mode = 2'($urandom_range(0, 3));
        if (p % FT == r2) vid.mode = 2'((p / FT + 1) % 4);
      end
    end
    // Asynchronous reset in the middle of line 20 of the next frame.
    rst_at = 8 * FT + 20 * HT + $urandom_range(0, HT - 1);
    while (kcyc - 2 < rst_at) step();
    #3 rst_n = 1'b0;
    #1 chk("async_rst", obs_vec(), RST_VEC);
    vid.mode = 2'd1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_val", obs_vec(), RST_VEC);
    end
    rst_n = 1'b1;
    restart_stats();
    while (kcyc < 2 * FT + 2) begin
      step();
      if (kcyc - 2 == FT / 3) vid.mode = 2'($urandom_range(0, 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48: horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33: vertical porch and sync widths in lines.
REQ-005 SHALL have parameter SYNC_POL, default 0: sync asserted level (0 = active-low).
REQ-006 SHALL have parameter COORD_W, default 10: width of x, y and internal counters.
REQ-007 SHALL have port clk, input, 1: pixel clock; single clock domain.
REQ-008 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port mode, input, 2: pattern select.
REQ-010 SHALL have port hsync, output, 1: horizontal sync at SYNC_POL.
REQ-011 SHALL have port vsync, output, 1: vertical sync at SYNC_POL.
REQ-012 SHALL have port de, output, 1: display enable, high in the active region.
REQ-013 SHALL have ports x and y, outputs, COORD_W each: current pixel coordinates.
REQ-014 SHALL have port rgb, output, 6: RGB222 packed {R1,R0,G1,G0,B1,B0}.
REQ-015 SHALL have port frame_start, output, 1: one-clock pulse at (0,0).

Function
REQ-016 SHALL run h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H_*), wrapping to 0 and incrementing v_cnt; v_cnt wraps 0..V_TOTAL-1 when h_cnt wraps on the last line.
REQ-017 SHALL register all outputs in one stage, so hsync, vsync, de, x, y, rgb and frame_start are mutually aligned and reflect the counter value of the previous clock.
REQ-018 SHALL assert hsync for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], on every line including blanking lines.
REQ-019 SHALL assert vsync for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] across whole lines.
REQ-020 SHALL set de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE); x = h_cnt and y = v_cnt while de is high, else 0.
REQ-021 SHALL force rgb = 0 whenever de is low.
REQ-022 SHALL latch mode only at h_cnt = 0, v_cnt = 0; mid-frame mode changes take effect from the next frame.
REQ-023 mode 0 SHALL output 8 vertical colour bars of width H_ACTIVE/8 (integer, last bar absorbs the remainder), ordered white 111111, yellow 111100, cyan 001111, green 001100, magenta 110011, red 110000, blue 000011, black 000000, using a bar sub-counter (no divider).
REQ-024 mode 1 SHALL output a checkerboard: rgb = 111111 if px[5]^y[5], else 000000.
REQ-025 mode 2 SHALL output a gradient: rgb = {px[7:6], y[7:6], px[8:7]}.
REQ-026 mode 3 SHALL output a border: 111111 at x = 0, x = H_ACTIVE-1, y = 0 or y = V_ACTIVE-1, else 000000.
REQ-027 px SHALL equal x, except as modified under Configuration; arithmetic wraps modulo 2^COORD_W.
REQ-028 SHALL pulse frame_start for exactly one clock per frame, aligned with the output of pixel (0,0).

Reset
REQ-029 While rst_n is low, counters and the latched mode SHALL be 0, and outputs SHALL be: hsync = vsync = !SYNC_POL, de = 0, x = y = 0, rgb = 0, frame_start = 0.
REQ-030 Reset assertion mid-frame SHALL take effect immediately, asynchronously.
REQ-031 On release, the first clock edge SHALL latch mode and the second SHALL output pixel (0,0) with frame_start high.

Configuration
REQ-032 With VGA_SCROLL_EN defined, the block SHALL contain an 8-bit frame counter, reset to 0 and incremented at each frame start, and SHALL set px = x + frame_cnt for modes 1 and 2 so the pattern scrolls left 1 px per frame.
REQ-033 With VGA_SCROLL_EN undefined, the block SHALL contain no frame counter and px = x in all modes; all other behaviour is unchanged.

Verification
REQ-034 Default params, reset release -> line period 800 clocks, frame period 420000 clocks between frame_start pulses.
REQ-035 Default params, SYNC_POL = 0 -> hsync low for 96 clocks starting at x-count 656; vsync low exactly on lines 490-491; de high 640x480 per frame.
REQ-036 mode 0 -> rgb 111111 at x = 0, 111100 at x = 80, 000011 at x = 559, 000000 at x = 639 and at all de = 0.
REQ-037 mode switched 0->1 at line 100 -> frame completes as bars; next frame checkerboard: (32,0) = 111111, (32,32) = 000000.
REQ-038 rst_n pulsed low at line 200 -> outputs at reset values within the same clock; after release, restart from (0,0) with frame_start.
REQ-039 VGA_SCROLL_EN defined, mode 1 -> pixel (0,0) of frame 32 is 111111 (frame 0: 000000); undefined -> identical every frame.
